microsequencer: RTL
===================

MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have parameter SELECTIONDECO, default 3, which is the width of each register-select output.
REQ-002 The block SHALL have parameter SELECTIONALU, default 3, which is the width of the ALU-select output.
REQ-003 The block SHALL have parameter ADDRWIDTH, default 5, which is the microprogram address width (legal range 1..8).
REQ-004 Ports SHALL be, in order:
- clk  in  1  system clock.
- lowRst  in  1  reset; one clock; reset is synchronous and active-low.
- sStart  in  1  launch/relaunch the microprogram.
- sMicroWord  in  16  microword at sMicroAddr, from an asynchronous ROM that is valid in the same cycle.
- sOverflow, sCarry, sNegative, sZero  in  1 each  ALU flags for the current cycle.
- sMicroAddr  out  ADDRWIDTH  program counter (PC).
- sSelDecoA, sSelDecoB, sSelDecoC  out  SELECTIONDECO  bus A/B source and bus C destination selects.
- sSelAlu  out  SELECTIONALU  ALU operation.
- sBusy  out  1  the block is in RUN or WAIT.
- sHalted  out  1  the block is in HALT.

Function
REQ-005 The microword opcode SHALL be op=[15:14]: 00 EXEC, 01 BRANCH, 10 HALT, 11 WAIT.
REQ-006 EXEC SHALL use these fields: selA=[13:11], selB=[10:8], selC=[7:5], alu=[4:2], latch=[1]; bit [0] is ignored.
REQ-007 BRANCH SHALL use these fields: cond=[13:11], target=[ADDRWIDTH-1:0].
REQ-008 The state machine SHALL have the states IDLE, RUN, WAIT and HALT, and SHALL enter IDLE on reset.
REQ-009 In IDLE, PC SHALL equal 0; sStart=1 SHALL go to RUN on the next edge; sStart=0 SHALL stay in IDLE.
REQ-010 In RUN with an EXEC word:
- sSelDecoA/B/C and sSelAlu SHALL equal the word fields combinationally in the same cycle.
- PC SHALL become PC+1 on the edge, wrapping from 2^ADDRWIDTH-1 to 0.
REQ-011 In RUN with EXEC and latch=1, the flag register {V,C,N,Z} SHALL load sOverflow/sCarry/sNegative/sZero on that edge; with latch=0 it SHALL hold.
REQ-012 BRANCH condition codes SHALL be evaluated on latched flags only: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 V, 7 never.
- Taken: PC SHALL become target on the edge.
- Not taken: PC SHALL become PC+1 with wrap.
REQ-013 A flag latch in cycle k SHALL be visible to a BRANCH in cycle k+1; there is no same-cycle flag bypass.
REQ-014 In RUN with a HALT word, the block SHALL go to HALT and PC SHALL hold the HALT address.
REQ-015 In HALT, sStart=1 SHALL go to RUN with PC=0 and flags cleared on the edge; otherwise the block SHALL stay in HALT.
REQ-016 In every cycle that is not RUN+EXEC, the outputs SHALL be parked: sSelDecoA=0, sSelDecoB=0, sSelDecoC=all ones (the non-writable fixed-register slot, so no register write), sSelAlu=0.
REQ-017 sStart SHALL be ignored in RUN and WAIT.
REQ-018 sBusy SHALL be 1 exactly in RUN or WAIT; sHalted SHALL be 1 exactly in HALT; both outputs SHALL be registered-state decodes.

Reset
REQ-019 While lowRst=0 at an edge, the block SHALL set state=IDLE, PC=0, flags=0 and WAIT counter=0.
REQ-020 Reset SHALL override any state, including mid-WAIT and mid-program.
REQ-021 Post-reset outputs SHALL be: sMicroAddr=0, selects parked per REQ-016, sBusy=0, sHalted=0.

Configuration
REQ-022 Macro MICROSEQ_WAIT_EN defined: in RUN, a WAIT word with N=[7:0] SHALL occupy exactly N+1 cycles at the same PC.
- The issuing cycle SHALL load an 8-bit counter with N and go to WAIT, or act as PC+1 if N=0.
- WAIT SHALL decrement the counter each cycle and, on reaching 0, go to RUN with PC+1.
- Outputs SHALL stay parked throughout, and flags SHALL hold.
REQ-023 Macro MICROSEQ_WAIT_EN undefined: the WAIT state and counter SHALL be absent, and op 11 SHALL behave as a NOP (parked outputs, PC+1, flags held).

Verification
REQ-024 Reset then sStart pulse: ROM[0]=EXEC selA=6,selB=7,selC=0,alu=0,latch=1 -> cycle after start sSelDecoA=6,sSelDecoB=7,sSelDecoC=0, PC 0->1, sBusy=1.
REQ-025 EXEC latch with sZero=1, then ROM[1]=BRANCH cond=1 target=5 -> PC=5; repeat with sZero=0 latched -> PC=2.
REQ-026 PC=31 (ADDRWIDTH=5) with an EXEC word -> PC=0 next cycle; BRANCH cond=7 -> PC+1; BRANCH cond=0 target=3 -> PC=3.
REQ-027 HALT at address 4 -> sHalted=1, PC=4, sSelDecoC=7 held; sStart=1 -> PC=0, flags=0, sBusy=1.
REQ-028 MICROSEQ_WAIT_EN defined, WAIT N=3 at address 2 -> PC=2 for exactly 4 cycles with parked selects, then PC=3; lowRst=0 during the second cycle -> IDLE, PC=0 next cycle.
REQ-029 MICROSEQ_WAIT_EN undefined, same WAIT word -> PC=3 after one cycle.

Source files
------------

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - microprogram sequencer: PC, flag register, branch and halt control.
// The optional multi-cycle WAIT opcode is built only when MICROSEQ_WAIT_EN is defined.
module microsequencer #(
    parameter int SELECTIONDECO = 3,
    parameter int SELECTIONALU  = 3,
    parameter int ADDRWIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     sStart,
    input  logic [15:0]              sMicroWord,
    input  logic                     sOverflow,
    input  logic                     sCarry,
    input  logic                     sNegative,
    input  logic                     sZero,
    output logic [ADDRWIDTH-1:0]     sMicroAddr,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sBusy,
    output logic                     sHalted
);

`ifdef MICROSEQ_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd3
    } state_t;
`endif

    localparam logic [1:0] OP_EXEC   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_WAIT   = 2'b11;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDRWIDTH-1:0]   r_pc;
    logic [ADDRWIDTH-1:0]   w_pc_nxt;
    logic [ADDRWIDTH-1:0]   w_pc_inc;
    logic [3:0]             r_flags;      // {V, C, N, Z}
    logic [3:0]             w_flags_nxt;
`ifdef MICROSEQ_WAIT_EN
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
`endif

    logic [1:0]             w_op;
    logic [2:0]             w_cond;
    logic [ADDRWIDTH-1:0]   w_target;
    logic                   w_latch;
    logic                   w_taken;
    logic                   w_unused_bit0;

    logic [SELECTIONDECO-1:0] w_sel_a;
    logic [SELECTIONDECO-1:0] w_sel_b;
    logic [SELECTIONDECO-1:0] w_sel_c;
    logic [SELECTIONALU-1:0]  w_sel_alu;

    assign w_op          = sMicroWord[15:14];
    assign w_cond        = sMicroWord[13:11];
    assign w_target      = sMicroWord[ADDRWIDTH-1:0];
    assign w_latch       = sMicroWord[1];
    assign w_unused_bit0 = sMicroWord[0];
    assign w_pc_inc      = r_pc + ADDRWIDTH'(1);

    // Branches look only at the registered flags, never at this cycle's ALU flags.
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            3'd0:    w_taken = 1'b1;
            3'd1:    w_taken = r_flags[0];
            3'd2:    w_taken = ~r_flags[0];
            3'd3:    w_taken = r_flags[2];
            3'd4:    w_taken = ~r_flags[2];
            3'd5:    w_taken = r_flags[1];
            3'd6:    w_taken = r_flags[3];
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!lowRst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_flags <= '0;
`ifdef MICROSEQ_WAIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
`ifdef MICROSEQ_WAIT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // Selects are parked (C = all ones, the unwritable slot) unless executing an EXEC word.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
`ifdef MICROSEQ_WAIT_EN
        w_cnt_nxt   = r_cnt;
`endif
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_c     = '1;
        w_sel_alu   = '0;
        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = '0;
                if (sStart) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                case (w_op)
                    OP_EXEC: begin
                        w_sel_a   = SELECTIONDECO'(sMicroWord[13:11]);
                        w_sel_b   = SELECTIONDECO'(sMicroWord[10:8]);
                        w_sel_c   = SELECTIONDECO'(sMicroWord[7:5]);
                        w_sel_alu = SELECTIONALU'(sMicroWord[4:2]);
                        w_pc_nxt  = w_pc_inc;
                        if (w_latch) begin
                            w_flags_nxt = {sOverflow, sCarry, sNegative, sZero};
                        end
                    end
                    OP_BRANCH: begin
                        w_pc_nxt = w_taken ? w_target : w_pc_inc;
                    end
                    OP_HALT: begin
                        w_state_nxt = ST_HALT;
                    end
                    OP_WAIT: begin
`ifdef MICROSEQ_WAIT_EN
                        if (sMicroWord[7:0] == 8'd0) begin
                            w_pc_nxt = w_pc_inc;
                        end else begin
                            w_cnt_nxt   = sMicroWord[7:0];
                            w_state_nxt = ST_WAIT;
                        end
`else
                        w_pc_nxt = w_pc_inc;
`endif
                    end
                    default: begin
                        w_state_nxt = ST_RUN;
                    end
                endcase
            end
`ifdef MICROSEQ_WAIT_EN
            ST_WAIT: begin
                // The issuing RUN cycle plus N WAIT cycles give N+1 cycles at this PC.
                if (r_cnt <= 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
`endif
            ST_HALT: begin
                if (sStart) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_flags_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    assign sMicroAddr = r_pc;
    assign sSelDecoA  = w_sel_a;
    assign sSelDecoB  = w_sel_b;
    assign sSelDecoC  = w_sel_c;
    assign sSelAlu    = w_sel_alu;
`ifdef MICROSEQ_WAIT_EN
    assign sBusy      = (r_state == ST_RUN) || (r_state == ST_WAIT);
`else
    assign sBusy      = (r_state == ST_RUN);
`endif
    assign sHalted    = (r_state == ST_HALT);

endmodule
